// File: rtl/uni2bin_pkg.sv
// uni2bin_pkg
// Shared types and helpers for the bipolar unary-to-binary accumulator.
//   acc_state_t : FSM state encoding (IDLE, WARM, ACC, DONE)
//   win_len     : accumulation window length, 2^bw
//   bip_offset  : bipolar zero point, 2^(bw-1)
package uni2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } acc_state_t;

    function automatic int win_len(input int bw);
        return 1 << bw;
    endfunction

    function automatic int bip_offset(input int bw);
        return 1 << (bw - 1);
    endfunction

endpackage

// File: rtl/uni2bin_win_cnt.sv
// uni2bin_win_cnt
// Up-counter with synchronous clear and enable.  It wraps to zero after
// reaching TC, and tc flags the enabled cycle in which that wrap happens.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : synchronous clear (count back to 0)
//   en  : count enable
//   tc  : terminal count, high while en && count == TC
module uni2bin_win_cnt #(
    parameter int             W  = 8,
    parameter logic [W-1:0]   TC = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;

    assign tc = en && (cnt_q == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/bipolar_uni2bin_acc.sv
// bipolar_uni2bin_acc
// Converts the bipolar quotient bitstream back to binary.  After an optional
// warm-up of DROP discarded cycles it counts the ones over 2^BW cycles.  The
// result is then offered on a valid/ready handshake.
//   clk       : clock
//   rst       : synchronous active-high reset
//   start     : begin a conversion (taken in IDLE, or in DONE together with out_ready)
//   in_bit    : bitstream input, 1 = +1, 0 = -1
//   busy      : high in WARM and ACC
//   out_valid : high in DONE
//   out_ready : consumer accepts the result
//   ones_cnt  : count of ones in the window, 0..2^BW
//   bip_val   : signed ones_cnt - 2^(BW-1)
//
// state | meaning
// IDLE  | waiting for start
// WARM  | discarding DROP start-up bits of the divider
// ACC   | counting ones over the 2^BW-cycle window
// DONE  | result valid, held until out_ready
module bipolar_uni2bin_acc
    import uni2bin_pkg::*;
#(
    parameter int BW    = 8,
    parameter int DROP  = 16,
    parameter int DROPW = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_bit,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [BW:0] ones_cnt,
    output logic [BW:0] bip_val
);

    localparam int             N       = win_len(BW);
    localparam logic [BW:0]    OFFSET  = (BW+1)'(bip_offset(BW));
    localparam logic [BW-1:0]  WIN_TC  = BW'(N - 1);
    // With DROP == 0 the warm-up counter is never enabled, so its TC value is unused.
    localparam logic [DROPW-1:0] WARM_TC = DROPW'((DROP > 0) ? DROP - 1 : 0);
    localparam acc_state_t     FIRST_ST = (DROP > 0) ? WARM : ACC;

    acc_state_t  state_q;
    acc_state_t  state_d;
    logic        start_go;
    logic        warm_tc;
    logic        win_tc;
    logic [BW:0] acc_q;

    // A conversion is launched from IDLE, or from DONE in the same cycle the
    // result is consumed; start in any other situation is dropped.
    assign start_go = start && ((state_q == IDLE) ||
                                ((state_q == DONE) && out_ready));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = FIRST_ST;
            WARM: if (warm_tc) state_d = ACC;
            ACC:  if (win_tc) state_d = DONE;
            DONE: if (out_ready) state_d = start ? FIRST_ST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    uni2bin_win_cnt #(
        .W  (DROPW),
        .TC (WARM_TC)
    ) u_warm_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_go),
        .en  (state_q == WARM),
        .tc  (warm_tc)
    );

    uni2bin_win_cnt #(
        .W  (BW),
        .TC (WIN_TC)
    ) u_win_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_go),
        .en  (state_q == ACC),
        .tc  (win_tc)
    );

    // The accumulator doubles as the result register: it stops changing once
    // ACC is left, so the count stays held until the next start clears it.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            acc_q <= '0;
        end else if (state_q == ACC) begin
            acc_q <= acc_q + {{BW{1'b0}}, in_bit};
        end
    end

    assign ones_cnt  = acc_q;
    assign bip_val   = acc_q - OFFSET;
    assign busy      = (state_q == WARM) || (state_q == ACC);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_bipolar_uni2bin_acc.sv
module tb_bipolar_uni2bin_acc;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst, start, in_bit, out_ready;
    logic sel;
    logic start0, start3;
    logic busy0, busy3, valid0, valid3;
    logic [4:0] ones0, ones3, bip0, bip3;
    logic busy_m, valid_m;
    logic [4:0] ones_m, bip_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start0  = start & ~sel;
    assign start3  = start & sel;
    assign busy_m  = sel ? busy3  : busy0;
    assign valid_m = sel ? valid3 : valid0;
    assign ones_m  = sel ? ones3  : ones0;
    assign bip_m   = sel ? bip3   : bip0;

    bipolar_uni2bin_acc #(.BW(4), .DROP(0), .DROPW(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_bit(in_bit),
        .busy(busy0), .out_valid(valid0), .out_ready(out_ready),
        .ones_cnt(ones0), .bip_val(bip0)
    );

    bipolar_uni2bin_acc #(.BW(4), .DROP(3), .DROPW(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_bit(in_bit),
        .busy(busy3), .out_valid(valid3), .out_ready(out_ready),
        .ones_cnt(ones3), .bip_val(bip3)
    );

    typedef struct {
        logic        sel;
        logic [31:0] pat;
        int          exp_ones;
        int          exp_bip;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int drop_of(input logic s);
        return s ? 3 : 0;
    endfunction

    // Reference: bit k-1 of pat is sampled at the k-th edge after the start
    // edge; the first DROP of those are discarded, the next N are counted.
    function automatic int model_ones(input logic s, input logic [31:0] pat);
        int c = 0;
        for (int i = drop_of(s); i < drop_of(s) + N; i++) c += int'(pat[i]);
        return c;
    endfunction

    function automatic int sbip();
        return int'($signed(bip_m));
    endfunction

    task automatic begin_conv();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds the pattern after a start edge until out_valid; edges counts the
    // start edge as 1.  ign_k > 0 pulses start at that edge (should be ignored).
    task automatic run_window(input logic [31:0] pat, input int ign_k, output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            in_bit = pat[k-1];
            start  = (k == ign_k);
            tick();
            start = 1'b0;
            if (k == 1) chk("busy_after_start", int'(busy_m), 1);
            if (valid_m) begin
                edges = k + 1;
                break;
            end
        end
    endtask

    task automatic accept();
        int held;
        held = int'(ones_m);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_valid", int'(valid_m), 0);
        chk("accept_busy", int'(busy_m), 0);
        chk("accept_hold", int'(ones_m), held);
    endtask

    task automatic full_conv(input logic s, input logic [31:0] pat, input int ign_k,
                             input int exp_ones, input string tag);
        int edges;
        sel = s;
        begin_conv();
        run_window(pat, ign_k, edges);
        chk({tag, "_latency"}, edges, 1 + drop_of(s) + N);
        chk({tag, "_ones"}, int'(ones_m), exp_ones);
        chk({tag, "_bip"}, sbip(), exp_ones - N/2);
    endtask

    initial begin
        int edges;
        logic [31:0] rp;
        logic rs;

        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 16,  8};
        tbl[1] = '{1'b0, 32'h0000_0000,  0, -8};
        tbl[2] = '{1'b0, 32'h5555_5555,  8,  0};
        tbl[3] = '{1'b0, 32'h0000_0001,  1, -7};
        tbl[4] = '{1'b1, 32'h0000_0007,  0, -8};
        tbl[5] = '{1'b1, 32'hFFFF_FFF8, 16,  8};
        tbl[6] = '{1'b1, 32'h0000_0008,  1, -7};
        tbl[7] = '{1'b1, 32'h000F_FFFF, 16,  8};

        rst = 1'b1; start = 1'b0; in_bit = 1'b0; out_ready = 1'b0; sel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_busy",  int'(busy_m), 0);
            chk("rst_valid", int'(valid_m), 0);
            chk("rst_ones",  int'(ones_m), 0);
            chk("rst_bip",   sbip(), -8);
        end

        for (int i = 0; i < 8; i++) begin
            full_conv(tbl[i].sel, tbl[i].pat, 0, tbl[i].exp_ones, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_bip_const", i), sbip(), tbl[i].exp_bip);
            accept();
        end

        // Backpressure: hold in DONE while in_bit toggles and start pulses.
        full_conv(1'b0, 32'hFFFF_FFFF, 0, 16, "bp");
        for (int c = 0; c < 10; c++) begin
            in_bit = c[0];
            start  = c[1];
            tick();
            start = 1'b0;
            chk("bp_valid", int'(valid_m), 1);
            chk("bp_busy", int'(busy_m), 0);
            chk("bp_ones", int'(ones_m), 16);
            chk("bp_bip", sbip(), 8);
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("b2b_busy", int'(busy_m), 1);
        chk("b2b_valid", int'(valid_m), 0);
        chk("b2b_cleared", int'(ones_m), 0);
        rp = 32'h0000_0F0F;
        run_window(rp, 0, edges);
        chk("b2b_latency", edges, 1 + N);
        chk("b2b_ones", int'(ones_m), model_ones(1'b0, rp));
        accept();

        // Start during ACC is ignored: one result, same timing.
        full_conv(1'b0, 32'h0000_3C3C, 5, 8, "ign");
        accept();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid_m || busy_m) begin
                chk("ign_extra_result", 1, 0);
                break;
            end
        end
        chk("ign_idle", int'(busy_m) + int'(valid_m), 0);

        // Reset after 7 counted ACC cycles aborts the conversion.
        sel = 1'b0;
        begin_conv();
        for (int k = 0; k < 7; k++) begin
            in_bit = 1'b1;
            tick();
        end
        chk("pre_rst_ones", int'(ones_m), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy_m), 0);
        chk("mid_rst_valid", int'(valid_m), 0);
        chk("mid_rst_ones", int'(ones_m), 0);
        chk("mid_rst_bip", sbip(), -8);
        rp = 32'hA5C3_96F0;
        full_conv(1'b0, rp, 0, model_ones(1'b0, rp), "post_rst");
        accept();

        // Randomized conversions against the counting model.
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(1, 0));
            rp = $urandom;
            full_conv(rs, rp, 0, model_ones(rs, rp), $sformatf("rnd%0d", i));
            for (int w = 0; w < int'($urandom_range(3, 0)); w++) begin
                in_bit = 1'($urandom);
                tick();
                chk("rnd_hold", int'(ones_m), model_ones(rs, rp));
            end
            accept();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
